// File: rtl/fwd_scoreboard_pkg.sv
// Shared definitions for the forwarding scoreboard.
//   - forwarding-select encoding (0 = register file, k = k stages after EX)
//   - layout of one in-flight tag: {v, we, rd[AW-1:0], ld}, ld at bit 0
//   - per-cycle slot action taken when loading entry 0
package fwd_scoreboard_pkg;

  localparam int FWD_SEL_RF   = 0;  // no bypass, operand comes from the regfile
  localparam int STAGE_EX_MEM = 1;  // distance of entry 0 (the instr now in EX)

  localparam int ENT_LD = 0;        // load flag
  localparam int ENT_RD = 1;        // lsb of destination register field

  function automatic int ent_we_pos(input int aw);
    return aw + 1;
  endfunction

  function automatic int ent_v_pos(input int aw);
    return aw + 2;
  endfunction

  function automatic int ent_width(input int aw);
    return aw + 3;
  endfunction

  typedef enum logic [1:0] {
    SLOT_BUBBLE = 2'd0,  // nothing issues (idle ID or load-use stall)
    SLOT_ISSUE  = 2'd1,  // ID instr moves into EX
    SLOT_FLUSH  = 2'd2   // ID and EX squashed
  } slot_act_e;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID-stage request / EX-stage result bundle of the forwarding scoreboard.
//   master: pipeline control (drives ID info and flush, receives stall/selects)
//   slave : the scoreboard
// Signals:
//   id_valid, id_src, id_src_used, id_we, id_rd, id_is_load  ID-stage instruction
//   ex_flush    squash ID and EX
//   stall       combinational load-use stall
//   ex_valid    EX holds a real instruction
//   ex_fwd_sel  per-source bypass select, src k at [k*SELW +: SELW]
//   stall_cnt   saturating stall-cycle counter
interface fwd_scoreboard_if #(
  parameter int AW      = 3,
  parameter int NUM_SRC = 2,
  parameter int SELW    = 2
);
  logic                     id_valid;
  logic [NUM_SRC*AW-1:0]    id_src;
  logic [NUM_SRC-1:0]       id_src_used;
  logic                     id_we;
  logic [AW-1:0]            id_rd;
  logic                     id_is_load;
  logic                     ex_flush;
  logic                     stall;
  logic                     ex_valid;
  logic [NUM_SRC*SELW-1:0]  ex_fwd_sel;
  logic [15:0]              stall_cnt;

  modport master (
    output id_valid, id_src, id_src_used, id_we, id_rd, id_is_load, ex_flush,
    input  stall, ex_valid, ex_fwd_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_we, id_rd, id_is_load, ex_flush,
    output stall, ex_valid, ex_fwd_sel, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard_match.sv
// Priority compare of one source operand against every in-flight tag.
// Ports:
//   ent_live  per-entry "writes a forwardable register" flag
//   ent_ld    per-entry load flag
//   ent_rd    per-entry destination, entry i at [i*AW +: AW]
//   src       source register address
//   src_used  source is actually read
//   sel       distance of nearest matching entry, FWD_SEL_RF if none
//   load_hit  some matching load is still too young to forward
module fwd_scoreboard_match
  import fwd_scoreboard_pkg::*;
#(
  parameter int AW       = 3,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 2,
  parameter int SELW     = 2
) (
  input  logic [DEPTH-1:0]    ent_live,
  input  logic [DEPTH-1:0]    ent_ld,
  input  logic [DEPTH*AW-1:0] ent_rd,
  input  logic [AW-1:0]       src,
  input  logic                src_used,
  output logic [SELW-1:0]     sel,
  output logic                load_hit
);

  // Walk from the oldest entry to the newest so the nearest match is the
  // last assignment and wins. load_hit looks at every match, not just the
  // nearest: an older young load still blocks even when shadowed.
  always_comb begin
    sel      = SELW'(FWD_SEL_RF);
    load_hit = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (src_used && ent_live[i] && (ent_rd[i*AW +: AW] == src)) begin
        sel = SELW'(i + STAGE_EX_MEM);
        if (ent_ld[i] && ((i + STAGE_EX_MEM) < LOAD_LAT)) begin
          load_hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding / load-use hazard scoreboard beside the ID/EX register.
// Keeps DEPTH tags of recently issued instructions (entry 0 = instr in EX),
// resolves per-source bypass selects at ID and registers them into EX,
// raises the load-use stall and counts stall cycles.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   fwd_scoreboard_if.slave (ID request in, stall/EX selects out)
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int AW       = 3,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 2,
  parameter int R0_ZERO  = 0
) (
  input  logic            clk,
  input  logic            rst,
  fwd_scoreboard_if.slave bus
);

  localparam int SELW = $clog2(DEPTH + 1);
  localparam int EW   = ent_width(AW);
  localparam int EV   = ent_v_pos(AW);
  localparam int EWE  = ent_we_pos(AW);

  logic [EW-1:0]           ent_q [DEPTH];
  logic [DEPTH-1:0]        ent_live;
  logic [DEPTH-1:0]        ent_ld;
  logic [DEPTH*AW-1:0]     ent_rd;
  logic [NUM_SRC*SELW-1:0] sel_all;
  logic [NUM_SRC-1:0]      load_hit;
  logic                    stall_c;
  slot_act_e               act;
  logic [EW-1:0]           new_tag;
  logic                    ex_valid_q;
  logic [NUM_SRC*SELW-1:0] ex_sel_q;
  logic [15:0]             stall_cnt_q;

  // Writes to r0 are invisible when R0_ZERO is set, so they never bypass
  // and never cause a load-use stall.
  always_comb begin
    ent_live = '0;
    ent_ld   = '0;
    ent_rd   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_live[i] = ent_q[i][EV] && ent_q[i][EWE] &&
                    !((R0_ZERO != 0) && (ent_q[i][ENT_RD +: AW] == '0));
      ent_ld[i]   = ent_q[i][ENT_LD];
      ent_rd[i*AW +: AW] = ent_q[i][ENT_RD +: AW];
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_scoreboard_match #(
      .AW       (AW),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .SELW     (SELW)
    ) u_match (
      .ent_live (ent_live),
      .ent_ld   (ent_ld),
      .ent_rd   (ent_rd),
      .src      (bus.id_src[k*AW +: AW]),
      .src_used (bus.id_src_used[k]),
      .sel      (sel_all[k*SELW +: SELW]),
      .load_hit (load_hit[k])
    );
  end

  // Stall is masked during reset so the held instr never sees stale tags,
  // and a flush overrides it since the ID instr is being squashed anyway.
  always_comb begin
    stall_c = !rst && bus.id_valid && !bus.ex_flush && (|load_hit);
    if (bus.ex_flush) begin
      act = SLOT_FLUSH;
    end else if (bus.id_valid && !stall_c) begin
      act = SLOT_ISSUE;
    end else begin
      act = SLOT_BUBBLE;
    end
  end

  always_comb begin
    new_tag                 = '0;
    new_tag[EV]             = (act == SLOT_ISSUE);
    new_tag[EWE]            = bus.id_we;
    new_tag[ENT_RD +: AW]   = bus.id_rd;
    new_tag[ENT_LD]         = bus.id_is_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      ex_valid_q  <= 1'b0;
      ex_sel_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      ent_q[0] <= new_tag;
      for (int i = 1; i < DEPTH; i++) begin
        ent_q[i] <= ent_q[i-1];
        // The instr leaving EX on a flush was squashed: age it as a bubble.
        if ((i == 1) && (act == SLOT_FLUSH)) begin
          ent_q[i][EV] <= 1'b0;
        end
      end
      ex_valid_q <= (act == SLOT_ISSUE);
      ex_sel_q   <= (act == SLOT_ISSUE) ? sel_all : '0;
      if (stall_c && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign bus.stall      = stall_c;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_fwd_sel = ex_sel_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;

  logic clk = 1'b0;
  logic rst;
  logic rst_req;
  int   tot = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  // a: default config; b: deeper board with zero register and late loads
  fwd_scoreboard_if #(.AW(3), .NUM_SRC(2), .SELW(2)) bus_a ();
  fwd_scoreboard_if #(.AW(3), .NUM_SRC(2), .SELW(2)) bus_b ();

  fwd_scoreboard #(.AW(3), .NUM_SRC(2), .DEPTH(2), .LOAD_LAT(2), .R0_ZERO(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  fwd_scoreboard #(.AW(3), .NUM_SRC(2), .DEPTH(3), .LOAD_LAT(3), .R0_ZERO(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    bit       v;
    bit       we;
    bit [2:0] rd;
    bit       ld;
  } ent_t;

  ent_t        hq [2][$];
  logic        exp_v [2];
  logic [3:0]  exp_sel [2];
  logic [15:0] exp_cnt [2];
  int          dep_m [2] = '{2, 3};
  int          lat_m [2] = '{2, 3};
  bit          r0_m  [2] = '{1'b0, 1'b1};

  // Apply one ID-stage request at the negedge; afterwards the registered
  // outputs show the result of the previous request and stall reflects this one.
  task automatic set_id(input logic v, input logic [5:0] src, input logic [1:0] used,
                        input logic we, input logic [2:0] rd, input logic ld, input logic fl);
    @(negedge clk);
    rst = rst_req;
    bus_a.id_valid = v; bus_a.id_src = src; bus_a.id_src_used = used;
    bus_a.id_we = we; bus_a.id_rd = rd; bus_a.id_is_load = ld; bus_a.ex_flush = fl;
    bus_b.id_valid = v; bus_b.id_src = src; bus_b.id_src_used = used;
    bus_b.id_we = we; bus_b.id_rd = rd; bus_b.id_is_load = ld; bus_b.ex_flush = fl;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 6'd0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    idle();
    idle();
    rst_req = 1'b0;
  endtask

  // Reference: scan the issue history from newest to oldest.
  function automatic void model_eval(input ent_t h[$], input int lat, input bit r0,
                                     input logic [5:0] src, input logic [1:0] used,
                                     output logic [3:0] sel, output bit hz);
    sel = 4'd0;
    hz  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      logic [2:0] s;
      bit found;
      s = src[k*3 +: 3];
      found = 1'b0;
      for (int d = 1; d <= h.size(); d++) begin
        ent_t e;
        e = h[d-1];
        if (used[k] && e.v && e.we && !(r0 && e.rd == 3'd0) && e.rd == s) begin
          if (!found) begin
            sel[k*2 +: 2] = d[1:0];
            found = 1'b1;
          end
          if (e.ld && d < lat) hz = 1'b1;
        end
      end
    end
  endfunction

  task automatic test_reset();
    rst_req = 1'b1;
    idle();
    tot++; if (bus_a.stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b want=0", bus_a.stall); end
    set_id(1'b1, 6'd0, 2'b00, 1'b1, 3'd3, 1'b0, 1'b0);
    tot++; if (bus_a.ex_valid !== 1'b0) begin bad++; $display("FAIL rst_exv_a got=%0b want=0", bus_a.ex_valid); end
    tot++; if (bus_a.ex_fwd_sel !== 4'd0) begin bad++; $display("FAIL rst_sel_a got=%0h want=0", bus_a.ex_fwd_sel); end
    tot++; if (bus_a.stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt_a got=%0h want=0", bus_a.stall_cnt); end
    tot++; if (bus_b.ex_valid !== 1'b0) begin bad++; $display("FAIL rst_exv_b got=%0b want=0", bus_b.ex_valid); end
    rst_req = 1'b0;
    set_id(1'b1, {3'd0, 3'd3}, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0);
    tot++; if (bus_a.ex_valid !== 1'b0) begin bad++; $display("FAIL rst_beats_issue got=%0b want=0", bus_a.ex_valid); end
    tot++; if (bus_a.stall !== 1'b0) begin bad++; $display("FAIL rst_after_stall got=%0b want=0", bus_a.stall); end
    idle();
    tot++; if (bus_a.ex_valid !== 1'b1) begin bad++; $display("FAIL rst_first_issue got=%0b want=1", bus_a.ex_valid); end
    tot++; if (bus_a.ex_fwd_sel !== 4'd0) begin bad++; $display("FAIL rst_dropped_tag got=%0h want=0", bus_a.ex_fwd_sel); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1'b1, 6'd0, 2'b00, 1'b1, 3'd3, 1'b0, 1'b0);
    set_id(1'b1, {3'd0, 3'd3}, 2'b01, 1'b1, 3'd1, 1'b0, 1'b0);
    tot++; if (bus_a.stall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%0b want=0", bus_a.stall); end
    tot++; if (bus_a.ex_valid !== 1'b1) begin bad++; $display("FAIL b2b_exv got=%0b want=1", bus_a.ex_valid); end
    set_id(1'b1, {3'd3, 3'd0}, 2'b10, 1'b0, 3'd0, 1'b0, 1'b0);
    tot++; if (bus_a.ex_fwd_sel !== 4'b0001) begin bad++; $display("FAIL b2b_sel1 got=%0h want=1", bus_a.ex_fwd_sel); end
    idle();
    tot++; if (bus_a.ex_fwd_sel !== 4'b1000) begin bad++; $display("FAIL b2b_sel2 got=%0h want=8", bus_a.ex_fwd_sel); end
  endtask

  task automatic test_nearest();
    do_reset();
    set_id(1'b1, 6'd0, 2'b00, 1'b1, 3'd4, 1'b0, 1'b0);
    set_id(1'b1, 6'd0, 2'b00, 1'b1, 3'd4, 1'b0, 1'b0);
    set_id(1'b1, {3'd0, 3'd4}, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0);
    idle();
    tot++; if (bus_a.ex_fwd_sel !== 4'b0001) begin bad++; $display("FAIL nearest_sel got=%0h want=1", bus_a.ex_fwd_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 6'd0, 2'b00, 1'b1, 3'd5, 1'b1, 1'b0);
    set_id(1'b1, {3'd5, 3'd0}, 2'b10, 1'b1, 3'd6, 1'b0, 1'b0);
    tot++; if (bus_a.stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b want=1", bus_a.stall); end
    set_id(1'b1, {3'd5, 3'd0}, 2'b10, 1'b1, 3'd6, 1'b0, 1'b0);
    tot++; if (bus_a.stall !== 1'b0) begin bad++; $display("FAIL lu_stall_end got=%0b want=0", bus_a.stall); end
    tot++; if (bus_a.ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%0b want=0", bus_a.ex_valid); end
    tot++; if (bus_a.stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0h want=1", bus_a.stall_cnt); end
    idle();
    tot++; if (bus_a.ex_valid !== 1'b1) begin bad++; $display("FAIL lu_exv got=%0b want=1", bus_a.ex_valid); end
    tot++; if (bus_a.ex_fwd_sel !== 4'b1000) begin bad++; $display("FAIL lu_sel got=%0h want=8", bus_a.ex_fwd_sel); end
    tot++; if (bus_a.stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt_hold got=%0h want=1", bus_a.stall_cnt); end
  endtask

  task automatic test_unused_src();
    do_reset();
    set_id(1'b1, 6'd0, 2'b00, 1'b1, 3'd5, 1'b1, 1'b0);
    set_id(1'b1, {3'd5, 3'd5}, 2'b00, 1'b1, 3'd6, 1'b0, 1'b0);
    tot++; if (bus_a.stall !== 1'b0) begin bad++; $display("FAIL unused_stall got=%0b want=0", bus_a.stall); end
    idle();
    tot++; if (bus_a.ex_valid !== 1'b1) begin bad++; $display("FAIL unused_exv got=%0b want=1", bus_a.ex_valid); end
    tot++; if (bus_a.ex_fwd_sel !== 4'd0) begin bad++; $display("FAIL unused_sel got=%0h want=0", bus_a.ex_fwd_sel); end
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1'b1, 6'd0, 2'b00, 1'b1, 3'd2, 1'b0, 1'b0);
    set_id(1'b1, {3'd0, 3'd2}, 2'b01, 1'b1, 3'd7, 1'b0, 1'b1);
    tot++; if (bus_a.ex_valid !== 1'b1) begin bad++; $display("FAIL fl_pre_exv got=%0b want=1", bus_a.ex_valid); end
    set_id(1'b1, {3'd0, 3'd2}, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0);
    tot++; if (bus_a.ex_valid !== 1'b0) begin bad++; $display("FAIL fl_exv got=%0b want=0", bus_a.ex_valid); end
    idle();
    tot++; if (bus_a.ex_valid !== 1'b1) begin bad++; $display("FAIL fl_next_exv got=%0b want=1", bus_a.ex_valid); end
    tot++; if (bus_a.ex_fwd_sel !== 4'd0) begin bad++; $display("FAIL fl_sel got=%0h want=0", bus_a.ex_fwd_sel); end
    set_id(1'b1, 6'd0, 2'b00, 1'b1, 3'd5, 1'b1, 1'b0);
    set_id(1'b1, {3'd5, 3'd0}, 2'b10, 1'b1, 3'd6, 1'b0, 1'b1);
    tot++; if (bus_a.stall !== 1'b0) begin bad++; $display("FAIL fl_over_stall got=%0b want=0", bus_a.stall); end
    idle();
    tot++; if (bus_a.ex_valid !== 1'b0) begin bad++; $display("FAIL fl_squash_id got=%0b want=0", bus_a.ex_valid); end
    tot++; if (bus_a.stall_cnt !== 16'd0) begin bad++; $display("FAIL fl_cnt got=%0h want=0", bus_a.stall_cnt); end
  endtask

  task automatic test_r0_deep();
    do_reset();
    set_id(1'b1, 6'd0, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0);
    set_id(1'b1, {3'd0, 3'd0}, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0);
    tot++; if (bus_b.stall !== 1'b0) begin bad++; $display("FAIL r0_stall got=%0b want=0", bus_b.stall); end
    idle();
    tot++; if (bus_b.ex_fwd_sel !== 4'd0) begin bad++; $display("FAIL r0_sel_b got=%0h want=0", bus_b.ex_fwd_sel); end
    tot++; if (bus_b.ex_valid !== 1'b1) begin bad++; $display("FAIL r0_exv_b got=%0b want=1", bus_b.ex_valid); end
    tot++; if (bus_a.ex_fwd_sel !== 4'b0001) begin bad++; $display("FAIL r0_sel_a got=%0h want=1", bus_a.ex_fwd_sel); end
    set_id(1'b1, 6'd0, 2'b00, 1'b1, 3'd1, 1'b1, 1'b0);
    set_id(1'b1, {3'd0, 3'd1}, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0);
    tot++; if (bus_b.stall !== 1'b1) begin bad++; $display("FAIL deep_stall1 got=%0b want=1", bus_b.stall); end
    set_id(1'b1, {3'd0, 3'd1}, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0);
    tot++; if (bus_b.stall !== 1'b1) begin bad++; $display("FAIL deep_stall2 got=%0b want=1", bus_b.stall); end
    set_id(1'b1, {3'd0, 3'd1}, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0);
    tot++; if (bus_b.stall !== 1'b0) begin bad++; $display("FAIL deep_stall3 got=%0b want=0", bus_b.stall); end
    idle();
    tot++; if (bus_b.ex_fwd_sel !== 4'b0011) begin bad++; $display("FAIL deep_sel got=%0h want=3", bus_b.ex_fwd_sel); end
    tot++; if (bus_b.stall_cnt !== 16'd2) begin bad++; $display("FAIL deep_cnt got=%0h want=2", bus_b.stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1'b1, 6'd0, 2'b00, 1'b1, 3'd5, 1'b1, 1'b0);
    set_id(1'b1, {3'd5, 3'd0}, 2'b10, 1'b1, 3'd6, 1'b0, 1'b0);
    tot++; if (bus_a.stall !== 1'b1) begin bad++; $display("FAIL ms_stall got=%0b want=1", bus_a.stall); end
    rst_req = 1'b1;
    set_id(1'b1, {3'd5, 3'd0}, 2'b10, 1'b1, 3'd6, 1'b0, 1'b0);
    tot++; if (bus_a.stall !== 1'b0) begin bad++; $display("FAIL ms_rst_stall got=%0b want=0", bus_a.stall); end
    tot++; if (bus_a.stall_cnt !== 16'd1) begin bad++; $display("FAIL ms_cnt_pre got=%0h want=1", bus_a.stall_cnt); end
    rst_req = 1'b0;
    set_id(1'b1, {3'd5, 3'd0}, 2'b10, 1'b1, 3'd6, 1'b0, 1'b0);
    tot++; if (bus_a.stall !== 1'b0) begin bad++; $display("FAIL ms_post_stall got=%0b want=0", bus_a.stall); end
    tot++; if (bus_a.ex_valid !== 1'b0) begin bad++; $display("FAIL ms_exv got=%0b want=0", bus_a.ex_valid); end
    tot++; if (bus_a.stall_cnt !== 16'd0) begin bad++; $display("FAIL ms_cnt got=%0h want=0", bus_a.stall_cnt); end
    idle();
    tot++; if (bus_a.ex_valid !== 1'b1) begin bad++; $display("FAIL ms_reissue got=%0b want=1", bus_a.ex_valid); end
    tot++; if (bus_a.ex_fwd_sel !== 4'd0) begin bad++; $display("FAIL ms_sel got=%0h want=0", bus_a.ex_fwd_sel); end
  endtask

  task automatic test_saturation();
    do_reset();
    idle();
    force dut_a.stall_cnt_q = 16'hFFFE;
    #1;
    release dut_a.stall_cnt_q;
    #1;
    tot++; if (bus_a.stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_preset got=%0h want=fffe", bus_a.stall_cnt); end
    set_id(1'b1, 6'd0, 2'b00, 1'b1, 3'd5, 1'b1, 1'b0);
    set_id(1'b1, {3'd5, 3'd0}, 2'b10, 1'b1, 3'd6, 1'b0, 1'b0);
    set_id(1'b1, {3'd5, 3'd0}, 2'b10, 1'b1, 3'd6, 1'b0, 1'b0);
    tot++; if (bus_a.stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%0h want=ffff", bus_a.stall_cnt); end
    set_id(1'b1, 6'd0, 2'b00, 1'b1, 3'd7, 1'b1, 1'b0);
    set_id(1'b1, {3'd0, 3'd7}, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0);
    tot++; if (bus_a.stall !== 1'b1) begin bad++; $display("FAIL sat_stall got=%0b want=1", bus_a.stall); end
    set_id(1'b1, {3'd0, 3'd7}, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0);
    tot++; if (bus_a.stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%0h want=ffff", bus_a.stall_cnt); end
    idle();
    tot++; if (bus_a.stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold2 got=%0h want=ffff", bus_a.stall_cnt); end
  endtask

  task automatic test_random();
    ent_t bub;
    bub.v = 1'b0; bub.we = 1'b0; bub.rd = 3'd0; bub.ld = 1'b0;
    do_reset();
    for (int m = 0; m < 2; m++) begin
      hq[m].delete();
      for (int d = 0; d < dep_m[m]; d++) hq[m].push_back(bub);
      exp_v[m] = 1'b0; exp_sel[m] = 4'd0; exp_cnt[m] = 16'd0;
    end
    for (int n = 0; n < 3000; n++) begin
      logic v, we, ld, fl;
      logic [2:0] s0, s1, rd;
      logic [1:0] used;
      rst_req = ($urandom_range(0, 63) == 0);
      v    = ($urandom_range(0, 3) != 0);
      s0   = 3'($urandom_range(0, 3));
      s1   = 3'($urandom_range(0, 3));
      used = 2'($urandom_range(0, 3));
      we   = ($urandom_range(0, 3) != 0);
      rd   = 3'($urandom_range(0, 3));
      ld   = ($urandom_range(0, 2) == 0);
      fl   = ($urandom_range(0, 9) == 0);
      set_id(v, {s1, s0}, used, we, rd, ld, fl);
      for (int m = 0; m < 2; m++) begin
        logic [3:0] msel;
        bit hz, es, iss;
        logic o_stall, o_v;
        logic [3:0] o_sel;
        logic [15:0] o_cnt;
        model_eval(hq[m], lat_m[m], r0_m[m], {s1, s0}, used, msel, hz);
        es  = !rst_req && v && !fl && hz;
        iss = v && !es && !fl;
        o_stall = (m == 0) ? bus_a.stall      : bus_b.stall;
        o_v     = (m == 0) ? bus_a.ex_valid   : bus_b.ex_valid;
        o_sel   = (m == 0) ? bus_a.ex_fwd_sel : bus_b.ex_fwd_sel;
        o_cnt   = (m == 0) ? bus_a.stall_cnt  : bus_b.stall_cnt;
        tot++; if (o_stall !== es) begin bad++; $display("FAIL rnd_stall inst=%0d cyc=%0d got=%0b want=%0b", m, n, o_stall, es); end
        tot++; if (o_v !== exp_v[m]) begin bad++; $display("FAIL rnd_exv inst=%0d cyc=%0d got=%0b want=%0b", m, n, o_v, exp_v[m]); end
        tot++; if (o_sel !== exp_sel[m]) begin bad++; $display("FAIL rnd_sel inst=%0d cyc=%0d got=%0h want=%0h", m, n, o_sel, exp_sel[m]); end
        tot++; if (o_cnt !== exp_cnt[m]) begin bad++; $display("FAIL rnd_cnt inst=%0d cyc=%0d got=%0h want=%0h", m, n, o_cnt, exp_cnt[m]); end
        if (rst_req) begin
          hq[m].delete();
          for (int d = 0; d < dep_m[m]; d++) hq[m].push_back(bub);
          exp_v[m] = 1'b0; exp_sel[m] = 4'd0; exp_cnt[m] = 16'd0;
        end else begin
          ent_t ne, e0;
          if (fl) begin
            e0 = hq[m][0];
            e0.v = 1'b0;
            hq[m][0] = e0;
          end
          ne.v = iss; ne.we = we; ne.rd = rd; ne.ld = ld;
          hq[m].push_front(ne);
          void'(hq[m].pop_back());
          exp_v[m]   = iss;
          exp_sel[m] = iss ? msel : 4'd0;
          if (es && exp_cnt[m] != 16'hFFFF) exp_cnt[m] = exp_cnt[m] + 16'd1;
        end
      end
    end
    rst_req = 1'b0;
  endtask

  initial begin
    rst_req = 1'b1;
    rst = 1'b1;
    test_reset();
    test_back_to_back();
    test_nearest();
    test_load_use();
    test_unused_src();
    test_flush();
    test_r0_deep();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
